// File: rtl/voice_mixer.sv
// voice_mixer: N-voice polyphonic mixer feeding the PDM output stage.
// For each audio sample it scales every voice's oscillator sample by the
// voice's envelope, sums the enabled voices, applies master gain and
// saturates. The result is an offset-binary sample.
// Voices are handled one per clock, so one voice multiplier is shared.
// Optional feature: define VOICE_MIXER_CLIP_COUNT_EN to add a saturating
// 16-bit count of clipped mixes on port clip_count.
module voice_mixer #(
  parameter int NUM_VOICES     = 4,
  parameter int AMPLITUDE_BITS = 24,
  parameter int GAIN_BITS      = 8
) (
  input  logic                                 CLOCK_50,
  input  logic                                 reset,
  input  logic                                 sample_tick,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] osc_in,
  input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] env_in,
  input  logic [NUM_VOICES-1:0]                voice_enable,
  input  logic [GAIN_BITS-1:0]                 master_gain,
  output logic [AMPLITUDE_BITS-1:0]            mix_out,
  output logic                                 mix_valid,
  output logic                                 busy,
  output logic                                 clipped,
`ifdef VOICE_MIXER_CLIP_COUNT_EN
  output logic [15:0]                          clip_count,
`endif
  output logic                                 overrun
);

  localparam int AB = AMPLITUDE_BITS;
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  // Accumulator is wide enough that summing all voices can never wrap.
  localparam int AW = AB + $clog2(NUM_VOICES) + 1;
  // Signed voice sample times zero-extended envelope.
  localparam int PW = 2 * AB + 1;
  // Signed accumulator times zero-extended master gain.
  localparam int GW = AW + GAIN_BITS + 1;

  localparam logic [AB-1:0]        MID      = {1'b1, {(AB-1){1'b0}}};
  localparam logic [VW-1:0]        LAST_IDX = VW'(NUM_VOICES - 1);
  localparam logic signed [GW-1:0] G_MAX    = {{(GW-AB+1){1'b0}}, {(AB-1){1'b1}}};
  localparam logic signed [GW-1:0] G_MIN    = {{(GW-AB+1){1'b1}}, {(AB-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [VW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [AB-1:0]           osc_q [NUM_VOICES];
  logic [AB-1:0]           osc_d [NUM_VOICES];
  logic [AB-1:0]           env_q [NUM_VOICES];
  logic [AB-1:0]           env_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   en_q, en_d;
  logic [GAIN_BITS-1:0]    gain_q, gain_d;
  logic [AB-1:0]           mix_out_q, mix_out_d;
  logic                    mix_valid_q, mix_valid_d;
  logic                    busy_q, busy_d;
  logic                    clipped_q, clipped_d;
  logic                    overrun_q, overrun_d;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
  logic [15:0]             clip_count_q, clip_count_d;
`endif

  logic signed [AB-1:0]    voice_centered;
  logic signed [PW-1:0]    voice_prod;
  logic signed [AW-1:0]    voice_term;
  logic signed [GW-1:0]    gain_prod;
  logic signed [GW-1:0]    gain_shift;
  logic signed [AB-1:0]    sat_val;
  logic                    clip_now;

  // Datapath: current voice's enveloped term, and the gained/saturated mix.
  always_comb begin
    // Subtracting the midpoint from offset-binary is an MSB flip.
    voice_centered = {~osc_q[idx_q][AB-1], osc_q[idx_q][AB-2:0]};
    voice_prod     = PW'(voice_centered) * $signed({{(PW-AB){1'b0}}, env_q[idx_q]});
    voice_term     = AW'(voice_prod >>> AB);
    gain_prod      = GW'(acc_q) * $signed({{(GW-GAIN_BITS){1'b0}}, gain_q});
    gain_shift     = gain_prod >>> (GAIN_BITS - 1);
    if (gain_shift > G_MAX) begin
      sat_val  = G_MAX[AB-1:0];
      clip_now = 1'b1;
    end else if (gain_shift < G_MIN) begin
      sat_val  = G_MIN[AB-1:0];
      clip_now = 1'b1;
    end else begin
      sat_val  = gain_shift[AB-1:0];
      clip_now = 1'b0;
    end
  end

  // Control: next state, snapshot capture, accumulation and output update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    osc_d       = osc_q;
    env_d       = env_q;
    en_d        = en_q;
    gain_d      = gain_q;
    mix_out_d   = mix_out_q;
    mix_valid_d = 1'b0;
    clipped_d   = clipped_q;
    overrun_d   = overrun_q;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    clip_count_d = clip_count_q;
`endif
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            osc_d[v] = osc_in[v*AB +: AB];
            env_d[v] = env_in[v*AB +: AB];
          end
          en_d    = voice_enable;
          gain_d  = master_gain;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (en_q[idx_q]) begin
          acc_d = acc_q + voice_term;
        end else begin
          acc_d = acc_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + VW'(1);
        end
        if (sample_tick) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      SCALE: begin
        mix_out_d   = {~sat_val[AB-1], sat_val[AB-2:0]};
        clipped_d   = clip_now;
        mix_valid_d = 1'b1;
        state_d     = IDLE;
        // A tick coinciding with the result is dropped, not queued.
        if (sample_tick) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
`ifdef VOICE_MIXER_CLIP_COUNT_EN
        if (clip_now && (clip_count_q != 16'hFFFF)) begin
          clip_count_d = clip_count_q + 16'd1;
        end else begin
          clip_count_d = clip_count_q;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        osc_q[v] <= '0;
        env_q[v] <= '0;
      end
      en_q        <= '0;
      gain_q      <= '0;
      mix_out_q   <= MID;
      mix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      clipped_q   <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
      clip_count_q <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      osc_q       <= osc_d;
      env_q       <= env_d;
      en_q        <= en_d;
      gain_q      <= gain_d;
      mix_out_q   <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      busy_q      <= busy_d;
      clipped_q   <= clipped_d;
      overrun_q   <= overrun_d;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
      clip_count_q <= clip_count_d;
`endif
    end
  end

  assign mix_out   = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy      = busy_q;
  assign clipped   = clipped_q;
  assign overrun   = overrun_q;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
  assign clip_count = clip_count_q;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed and randomized checks of voice_mixer against an
// arithmetic reference model (4 voices, 24-bit amplitude, 8-bit gain).
module tb_voice_mixer;

  logic        CLOCK_50;
  logic        reset;
  logic        sample_tick;
  logic [95:0] osc_in;
  logic [95:0] env_in;
  logic [3:0]  voice_enable;
  logic [7:0]  master_gain;
  logic [23:0] mix_out;
  logic        mix_valid;
  logic        busy;
  logic        clipped;
  logic        overrun;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_count;
  int          exp_clips;
`endif

  int checks;
  int errors;
  int valid_cnt;

  voice_mixer #(.NUM_VOICES(4), .AMPLITUDE_BITS(24), .GAIN_BITS(8)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .osc_in       (osc_in),
    .env_in       (env_in),
    .voice_enable (voice_enable),
    .master_gain  (master_gain),
    .mix_out      (mix_out),
    .mix_valid    (mix_valid),
    .busy         (busy),
    .clipped      (clipped),
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    .clip_count   (clip_count),
`endif
    .overrun      (overrun)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  // Count result pulses, sampled mid-cycle.
  always @(negedge CLOCK_50) begin
    if (mix_valid === 1'b1) valid_cnt <= valid_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    if (a >= 0) return a / b;
    else return -((-a + b - 1) / b);
  endfunction

  // Reference: sum of floor(centered*env/2^24) over enabled voices,
  // then floor(sum*gain/128), clamped to the signed 24-bit range.
  task automatic model(input logic [95:0] o, input logic [95:0] e, input logic [3:0] en,
                       input logic [7:0] g, output logic [23:0] mo, output logic cl);
    longint acc, s, ev, r, gl;
    acc = 0;
    for (int v = 0; v < 4; v++) begin
      if (en[v]) begin
        s   = o[v*24 +: 24];
        ev  = e[v*24 +: 24];
        s   = s - 64'sd8388608;
        acc = acc + fdiv(s * ev, 64'sd16777216);
      end
    end
    gl = g;
    r  = fdiv(acc * gl, 64'sd128);
    cl = 1'b0;
    if (r > 64'sd8388607) begin
      r  = 64'sd8388607;
      cl = 1'b1;
    end else if (r < -64'sd8388608) begin
      r  = -64'sd8388608;
      cl = 1'b1;
    end
    r  = r + 64'sd8388608;
    mo = r[23:0];
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    exp_clips = 0;
`endif
  endtask

  // One full mix; inputs are scrambled right after the tick to prove the snapshot.
  task automatic do_mix(input string tag, input logic [95:0] o, input logic [95:0] e,
                        input logic [3:0] en, input logic [7:0] g);
    logic [23:0] emo;
    logic        ecl;
    int          lat;
    model(o, e, en, g, emo, ecl);
    @(posedge CLOCK_50); #1;
    osc_in = o; env_in = e; voice_enable = en; master_gain = g; sample_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_tick  = 1'b0;
    osc_in       = {$urandom, $urandom, $urandom};
    env_in       = {$urandom, $urandom, $urandom};
    voice_enable = 4'($urandom);
    master_gain  = 8'($urandom);
    lat = 1;
    check({tag, ".busy"}, {31'd0, busy}, 32'd1);
    while (mix_valid !== 1'b1 && lat < 20) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    check({tag, ".latency"}, lat, 32'd6);
    check({tag, ".mix_out"}, {8'd0, mix_out}, {8'd0, emo});
    check({tag, ".clipped"}, {31'd0, clipped}, {31'd0, ecl});
    check({tag, ".busy_done"}, {31'd0, busy}, 32'd0);
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    if (ecl && exp_clips < 65535) exp_clips++;
    check({tag, ".clip_count"}, clip_count, exp_clips);
`endif
  endtask

  initial begin
    int v0;
    logic [95:0] t1_osc, t1_env, full_osc, zero_osc;
    checks = 0; errors = 0; valid_cnt = 0;
    reset = 1'b1; sample_tick = 1'b0;
    osc_in = '0; env_in = '0; voice_enable = '0; master_gain = '0;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    exp_clips = 0;
`endif
    t1_osc   = {24'h800000, 24'h800000, 24'h800000, 24'hC00000};
    t1_env   = {24'h0, 24'h0, 24'h0, 24'hFFFFFF};
    full_osc = {4{24'hC00000}};
    zero_osc = {4{24'h000000}};

    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset.mix_out", {8'd0, mix_out}, 32'h800000);
    check("reset.mix_valid", {31'd0, mix_valid}, 32'd0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.clipped", {31'd0, clipped}, 32'd0);
    check("reset.overrun", {31'd0, overrun}, 32'd0);
    reset = 1'b0;

    do_mix("unity", t1_osc, t1_env, 4'b0001, 8'h80);
    check("unity.value", {8'd0, mix_out}, 32'hBFFFFF);
    do_mix("posclip", full_osc, {4{24'hFFFFFF}}, 4'b1111, 8'h80);
    check("posclip.value", {8'd0, mix_out}, 32'hFFFFFF);
    do_mix("negclip", zero_osc, {4{24'hFFFFFF}}, 4'b0011, 8'h80);
    check("negclip.value", {8'd0, mix_out}, 32'h000000);
    do_mix("disabled", full_osc, {4{24'hFFFFFF}}, 4'b0000, 8'h80);
    do_mix("gain0", full_osc, {4{24'hFFFFFF}}, 4'b1111, 8'h00);
    do_mix("halfgain", t1_osc, t1_env, 4'b0001, 8'h40);
    check("halfgain.value", {8'd0, mix_out}, 32'h9FFFFF);
    check("no_overrun_yet", {31'd0, overrun}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      do_mix($sformatf("rand%0d", i), {$urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom}, 4'($urandom), 8'($urandom));
    end

    // Second tick two cycles into a mix: one result, overrun set.
    @(posedge CLOCK_50); #1;
    v0 = valid_cnt;
    osc_in = t1_osc; env_in = t1_env; voice_enable = 4'b0001; master_gain = 8'h80;
    sample_tick = 1'b1;
    @(posedge CLOCK_50); #1; sample_tick = 1'b0;
    @(posedge CLOCK_50); #1; sample_tick = 1'b1;
    @(posedge CLOCK_50); #1; sample_tick = 1'b0;
    repeat (15) @(posedge CLOCK_50);
    #1;
    check("overrun.valid_count", valid_cnt - v0, 32'd1);
    check("overrun.flag", {31'd0, overrun}, 32'd1);
    check("overrun.mix_out", {8'd0, mix_out}, 32'hBFFFFF);

    // Tick in the cycle the result appears is dropped.
    do_reset();
    check("reset2.overrun", {31'd0, overrun}, 32'd0);
    @(posedge CLOCK_50); #1;
    v0 = valid_cnt;
    sample_tick = 1'b1;
    @(posedge CLOCK_50); #1; sample_tick = 1'b0;
    repeat (4) @(posedge CLOCK_50);
    #1 sample_tick = 1'b1;
    @(posedge CLOCK_50); #1; sample_tick = 1'b0;
    check("edge_tick.mix_valid", {31'd0, mix_valid}, 32'd1);
    @(posedge CLOCK_50); #1;
    check("edge_tick.busy", {31'd0, busy}, 32'd0);
    check("edge_tick.overrun", {31'd0, overrun}, 32'd1);
    repeat (10) @(posedge CLOCK_50);
    #1;
    check("edge_tick.valid_count", valid_cnt - v0, 32'd1);

    // Reset three cycles into a mix aborts it.
    do_reset();
    @(posedge CLOCK_50); #1;
    v0 = valid_cnt;
    osc_in = full_osc; env_in = {4{24'hFFFFFF}}; voice_enable = 4'b1111; master_gain = 8'h80;
    sample_tick = 1'b1;
    @(posedge CLOCK_50); #1; sample_tick = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b1;
    #1;
    check("abort.mix_out", {8'd0, mix_out}, 32'h800000);
    check("abort.busy", {31'd0, busy}, 32'd0);
    check("abort.overrun", {31'd0, overrun}, 32'd0);
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 1'b0;
`ifdef VOICE_MIXER_CLIP_COUNT_EN
    exp_clips = 0;
`endif
    repeat (12) @(posedge CLOCK_50);
    #1;
    check("abort.valid_count", valid_cnt - v0, 32'd0);
    check("abort.mix_out_after", {8'd0, mix_out}, 32'h800000);

`ifdef VOICE_MIXER_CLIP_COUNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) begin
      do_mix($sformatf("cc_clip%0d", i), full_osc, {4{24'hFFFFFF}}, 4'b1111, 8'h80);
    end
    do_mix("cc_clean", t1_osc, t1_env, 4'b0001, 8'h80);
    check("clip_count.total", clip_count, 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
